// File: rtl/fifo4_16bit.sv
// ---------------------------------------------------------------------------
// fifo4_16bit -- 4-entry x 16-bit first-word-fall-through FIFO
//
// Storage is four 16-bit registers. A 2-bit write pointer (wp) and a 2-bit
// read pointer (rp) address them. A separate 3-bit count register tracks the
// fill level. The head entry is selected by rp through a 4:1 word mux. The
// output is forced to zero while the FIFO is empty.
//
// Ports
//   clk       in   1   single clock, all state updates on its rising edge
//   reset     in   1   synchronous active-high reset
//   in        in  16   write data word
//   push      in   1   write request for 'in'
//   pop       in   1   read request, consumes the word currently on 'out'
//   out       out 16   head-of-queue word (first-word-fall-through)
//   full      out  1   4 words stored
//   empty     out  1   0 words stored
//   count     out  3   number of stored words, 0..4
//   overflow  out  1   sticky flag, set by a push rejected while full
//
// This file also contains Mux4way16bit, the 4:1 x 16-bit word mux that
// drives the head word.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// Mux4way16bit -- 4:1 multiplexer of 16-bit words
//
// Ports
//   select  in   2   selects inA (0), inB (1), inC (2) or inD (3)
//   inA..D  in  16   candidate words
//   out     out 16   selected word
// ---------------------------------------------------------------------------
module Mux4way16bit (
  input  logic [1:0]  select,
  input  logic [15:0] inA,
  input  logic [15:0] inB,
  input  logic [15:0] inC,
  input  logic [15:0] inD,
  output logic [15:0] out
);

  always_comb begin
    // NOTE: every signal written in an always_comb block gets a value on
    // every path. A missing default or a missing case arm infers a latch.
    out = inA;
    unique case (select)
      2'd0:    out = inA;
      2'd1:    out = inB;
      2'd2:    out = inC;
      2'd3:    out = inD;
      default: out = inA;
    endcase
  end

endmodule

module fifo4_16bit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        push,
  input  logic        pop,
  output logic [15:0] out,
  output logic        full,
  output logic        empty,
  output logic [2:0]  count,
  output logic        overflow
);

  localparam int unsigned DEPTH = 4;

  // -------------------------------------------------------------------------
  // State registers and their next-state values
  // -------------------------------------------------------------------------
  logic [15:0] mem_q [DEPTH];
  logic [15:0] mem_d [DEPTH];
  logic [1:0]  wp_q, wp_d;
  logic [1:0]  rp_q, rp_d;
  logic [2:0]  count_q, count_d;
  logic        overflow_q, overflow_d;

  logic        push_ok;
  logic        pop_ok;
  logic [15:0] head_word;

  // Flags come from the count register only. Because of this, in, push and
  // pop never reach full, empty or count through combinational logic.
  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);

  // A push is accepted while full only if a pop frees a slot in the same
  // cycle. When the FIFO is full, wp equals rp, so the new word lands in the
  // slot that the pop releases.
  assign push_ok = push && (!full || pop);

  // A pop on an empty FIFO is dropped. This includes a simultaneous push and
  // pop while empty: the push is accepted and the pop is ignored.
  assign pop_ok  = pop && !empty;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: combinational blocks use blocking '='. Registers are updated
    // only in always_ff with non-blocking '<=', so every process sees
    // consistent values at a clock edge.
    mem_d      = mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      mem_d[wp_q] = in;
      wp_d        = wp_q + 2'd1;   // 2-bit add wraps 3 -> 0
    end

    // The popped entry keeps its value; only the read pointer moves.
    if (pop_ok) begin
      rp_d = rp_q + 2'd1;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // Sticky: only reset clears it.
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage array is cleared on reset here. Stale words must
      // never become observable after a mid-operation reset. Storage arrays
      // that do not need this are normally left unreset so they map to RAM.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
      wp_q       <= 2'd0;
      rp_q       <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output path
  // -------------------------------------------------------------------------
  Mux4way16bit u_head_mux (
    .select (rp_q),
    .inA    (mem_q[0]),
    .inB    (mem_q[1]),
    .inC    (mem_q[2]),
    .inD    (mem_q[3]),
    .out    (head_word)
  );

  // Entries keep their data after being popped. Because of that, the head
  // word is masked while empty instead of relying on the entry contents.
  assign out      = empty ? 16'h0000 : head_word;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fifo4_16bit.sv
// ---------------------------------------------------------------------------
// tb_fifo4_16bit -- directed self-checking bench for fifo4_16bit
//
// Basic push/pop and fill/overflow/drain come from a vector table. Each row
// is applied for one clock cycle, and the outputs are compared 1 ns after the
// rising edge. The multi-cycle corner cases are written out by hand: pointer
// wrap, full push+pop, empty push+pop, and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_fifo4_16bit;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        push;
  logic        pop;
  logic [15:0] dout;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;

  int n_vec  = 0;
  int n_miss = 0;

  fifo4_16bit dut (
    .clk      (clk),
    .reset    (reset),
    .in       (din),
    .push     (push),
    .pop      (pop),
    .out      (dout),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        push;
    logic        pop;
    logic [15:0] din;
    logic [15:0] exp_out;
    logic [2:0]  exp_count;
    logic        exp_ovf;
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl [NVEC];

  // Drive one cycle of inputs and wait until just after the capturing edge.
  task automatic step(input logic r, input logic pu, input logic po,
                      input logic [15:0] d);
    reset = r;
    push  = pu;
    pop   = po;
    din   = d;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  // Compare all visible outputs. full and empty follow from the expected count.
  task automatic check(input string name, input logic [15:0] eo,
                       input logic [2:0] ec, input logic eov);
    logic ef, ee;
    ef = (ec == 3'd4);
    ee = (ec == 3'd0);
    n_vec++;
    if (dout !== eo || count !== ec || full !== ef || empty !== ee ||
        overflow !== eov) begin
      n_miss++;
      $display("FAIL %s: got out=%h count=%0d full=%b empty=%b ovf=%b, want out=%h count=%0d full=%b empty=%b ovf=%b",
               name, dout, count, full, empty, overflow, eo, ec, ef, ee, eov);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] got,
                            input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  initial begin
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    din   = 16'h0000;

    //           rst   push  pop   din       out       cnt   ovf
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0}; // reset
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'hA001, 16'hA001, 3'd1, 1'b0}; // push
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0, 1'b0}; // pop
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0001, 16'h0001, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 16'h0001, 3'd2, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0003, 16'h0001, 3'd3, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0004, 16'h0001, 3'd4, 1'b0}; // full
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h0001, 3'd4, 1'b1}; // overflow
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 3'd3, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 3'd2, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0004, 3'd1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0, 1'b1}; // drained
    tbl[12] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0, 1'b1}; // pop empty

    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].din);
      check($sformatf("vec%0d", i), tbl[i].exp_out, tbl[i].exp_count,
            tbl[i].exp_ovf);
    end

    // Pointer wrap: the fifth word overall lands in entry 0.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h1111);
    step(1'b0, 1'b1, 1'b0, 16'h2222);
    step(1'b0, 1'b1, 1'b0, 16'h3333);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("wrap_drained", 16'h0000, 3'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'hBEEF);
    check("wrap_beef", 16'hBEEF, 3'd1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'hCAFE);
    check("wrap_cafe_pushed", 16'hBEEF, 3'd2, 1'b0);
    check_word("wrap_entry0", dut.mem_q[0], 16'hCAFE);
    check_word("wrap_entry3", dut.mem_q[3], 16'hBEEF);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("wrap_pop1", 16'hCAFE, 3'd1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("wrap_pop2", 16'h0000, 3'd0, 1'b0);

    // Full with push and pop together.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0101);
    step(1'b0, 1'b1, 1'b0, 16'h0202);
    step(1'b0, 1'b1, 1'b0, 16'h0303);
    step(1'b0, 1'b1, 1'b0, 16'h0404);
    check("fpp_full", 16'h0101, 3'd4, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h7777);
    check("fpp_both", 16'h0202, 3'd4, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("fpp_pop1", 16'h0303, 3'd3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("fpp_pop2", 16'h0404, 3'd2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("fpp_pop3", 16'h7777, 3'd1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("fpp_pop4", 16'h0000, 3'd0, 1'b0);

    // Empty with push and pop together, then a lone pop on empty.
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    check("epp_both", 16'h1234, 3'd1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("epp_pop", 16'h0000, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("epp_pop_empty", 16'h0000, 3'd0, 1'b0);

    // Reset at count=3 with overflow set and a simultaneous push.
    step(1'b0, 1'b1, 1'b0, 16'h00A1);
    step(1'b0, 1'b1, 1'b0, 16'h00A2);
    step(1'b0, 1'b1, 1'b0, 16'h00A3);
    step(1'b0, 1'b1, 1'b0, 16'h00A4);
    step(1'b0, 1'b1, 1'b0, 16'h00A5);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("rst_pre", 16'h00A2, 3'd3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h9999);
    check("rst_push", 16'h0000, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_word($sformatf("rst_entry%0d", i), dut.mem_q[i], 16'h0000);
    end
    step(1'b0, 1'b1, 1'b0, 16'h5555);
    check("rst_then_push", 16'h5555, 3'd1, 1'b0);
    check_word("rst_push_entry0", dut.mem_q[0], 16'h5555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fifo4_16bit.md
FIFO4_16BIT -- requirements
Module: fifo4_16bit

Interface
REQ-001 SHALL have no parameters; depth is fixed at 4 entries and width at 16 bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in, input, 16, the write data word.
REQ-005 SHALL have port push, input, 1, write request for in.
REQ-006 SHALL have port pop, input, 1, read request; it consumes the word currently on out.
REQ-007 SHALL have port out, output, 16, the head-of-queue word (first-word-fall-through).
REQ-008 SHALL have port full, output, 1, high when 4 words are stored.
REQ-009 SHALL have port empty, output, 1, high when 0 words are stored.
REQ-010 SHALL have port count, output, 3, number of stored words, 0..4.
REQ-011 SHALL have port overflow, output, 1, sticky flag for a rejected push.

Function
REQ-012 SHALL store words in four 16-bit registers, entry 0..3, addressed by a 2-bit write pointer wp and a 2-bit read pointer rp.
REQ-013 SHALL drive out through one Mux4way16bit instance: select=rp; inA..inD = entry 0..3.
REQ-014 SHALL force out to 16'h0000 when empty=1, regardless of entry contents.
REQ-015 SHALL accept a push when push=1 and full=0: entry[wp]<=in, wp<=wp+1 mod 4.
REQ-016 SHALL accept a pop when pop=1 and empty=0: rp<=rp+1 mod 4; the popped entry keeps its value.
REQ-017 SHALL wrap both pointers 3->0 with no other side effect.
REQ-018 SHALL update count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-019 SHALL derive full=(count==4) and empty=(count==0) combinationally from the count register.
REQ-020 SHALL, when full and push=1 and pop=1, accept both; count stays 4, and the new word is written to the slot freed by the pop.
REQ-021 SHALL, when empty and push=1 and pop=1, ignore the pop and accept the push; count becomes 1.
REQ-022 SHALL ignore push when full and pop=0, leave storage and wp unchanged, and set overflow<=1.
REQ-023 SHALL ignore pop when empty, leaving all state unchanged; this is not an error.
REQ-024 SHALL keep overflow at 1 once set, until reset.
REQ-025 SHALL present a pushed word on out in the cycle after the push edge if the FIFO was empty, giving a write-to-read latency of 1 cycle.
REQ-026 SHALL make out change only after a clock edge; in, push and pop have no combinational path to out, full, empty or count.

Reset
REQ-027 SHALL, on a clk edge with reset=1, set wp=0, rp=0, count=0, overflow=0 and all four entries to 16'h0000.
REQ-028 SHALL give reset priority over push and pop in the same cycle; both are discarded.
REQ-029 SHALL, after reset, present out=16'h0000, empty=1, full=0, count=3'd0, overflow=0.
REQ-030 SHALL, on reset mid-operation with any fill level, discard all stored words; the next push after reset lands in entry 0.

Verification
REQ-031 Bench: reset, then push 16'hA001 -> next cycle out=16'hA001, count=1, empty=0; pop -> next cycle out=16'h0000, empty=1.
REQ-032 Bench: push 16'h0001..16'h0004 on consecutive cycles -> full=1, count=4; push 16'h0005 -> storage unchanged, overflow=1; pop four times -> out sequence 0001,0002,0003,0004, then empty=1.
REQ-033 Bench: wrap-around: push 3 words, pop 3, push 16'hBEEF,16'hCAFE -> the second word is written to entry 0 (wp wrapped), and out reads BEEF then CAFE in order.
REQ-034 Bench: full with push=1 and pop=1 and in=16'h7777 -> count stays 4, old head is removed, and 16'h7777 is read last.
REQ-035 Bench: empty with push=1 and pop=1 and in=16'h1234 -> count=1 and out=16'h1234 next cycle; pop on empty alone -> no change, overflow=0.
REQ-036 Bench: at count=3 assert reset together with push -> next cycle count=0, empty=1, out=0, overflow=0; then push 16'h5555 -> out=16'h5555.
